bin2bcd_feeder: RTL

BIN2BCD_FEEDER -- requirements
Module: bin2bcd_feeder

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin2bcd_feeder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD tube feeder: FSM encoding,
// parameter defaults and status register bit positions.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV    = 2'd1,
    WR_DATA = 2'd2,
    WR_SIGN = 2'd3
  } state_t;

  localparam int CONV_BITS_DEF = 27;
  localparam int MAX_DEC_DEF   = 99999999;
  localparam int BCD_DIGITS    = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_LOST = 2;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the BCD digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_feeder.sv
// CPU-writable value converted to 8 BCD digits by a serial double-dabble loop,
// then pushed to a digital-tube peripheral as a data word and a sign word.
// Build option: define BCD_SIGNED_EN to treat the written value as two's complement.
module bin2bcd_feeder
  import bcd_pkg::*;
#(
  parameter int CONV_BITS = CONV_BITS_DEF,
  parameter int MAX_DEC   = MAX_DEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic        addr,
  input  logic [31:0] din,
  output logic [31:0] RD,
  output logic        busy,
  output logic        tube_WE,
  output logic        tube_addr,
  output logic [31:0] tube_din
);

  localparam int                   CNT_W     = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(CONV_BITS - 1);
  localparam logic [32:0]          MAX_DEC_W = 33'(MAX_DEC);
  localparam logic [CONV_BITS-1:0] MAX_DEC_N = CONV_BITS'(MAX_DEC);

  state_t               state_reg, state_next;
  logic [31:0]          value_reg, value_next;
  logic                 neg_reg, neg_next;
  logic                 ovf_reg, ovf_next;
  logic                 lost_reg, lost_next;
  logic [CONV_BITS-1:0] shift_reg, shift_next;
  logic [31:0]          bcd_reg, bcd_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 tube_we_reg, tube_we_next;
  logic                 tube_addr_reg, tube_addr_next;
  logic [31:0]          tube_din_reg, tube_din_next;

  logic                 din_neg;
  logic [32:0]          din_mag;
  logic                 din_over;
  logic [CONV_BITS-1:0] mag_load;
  logic [31:0]          bcd_adj;
  logic [31:0]          bcd_shift;
  logic [31:0]          status_word;

  // 33-bit magnitude so that -2^31 negates without wrapping.
`ifdef BCD_SIGNED_EN
  assign din_neg = din[31];
  assign din_mag = din[31] ? (33'd0 - {din[31], din}) : {1'b0, din};
`else
  assign din_neg = 1'b0;
  assign din_mag = {1'b0, din};
`endif

  assign din_over = (din_mag > MAX_DEC_W);
  assign mag_load = din_over ? MAX_DEC_N : din_mag[CONV_BITS-1:0];

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit    (bcd_reg[4*gi +: 4]),
        .adjusted (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The top digit never exceeds 9 for displayable magnitudes, so its carry-out is dropped.
  assign bcd_shift = 32'({bcd_adj, shift_reg[CONV_BITS-1]});

  assign busy = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    value_next     = value_reg;
    neg_next       = neg_reg;
    ovf_next       = ovf_reg;
    lost_next      = lost_reg;
    shift_next     = shift_reg;
    bcd_next       = bcd_reg;
    cnt_next       = cnt_reg;
    tube_we_next   = 1'b0;
    tube_addr_next = 1'b0;
    tube_din_next  = '0;

    if (WE && addr && din[0]) begin
      ovf_next  = 1'b0;
      lost_next = 1'b0;
    end
    if (WE && !addr && busy) begin
      lost_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (WE && !addr) begin
          value_next = din;
          neg_next   = din_neg;
          ovf_next   = ovf_reg | din_over;
          shift_next = mag_load;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        bcd_next   = bcd_shift;
        shift_next = shift_reg << 1;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next    = WR_DATA;
          tube_we_next  = 1'b1;
          tube_din_next = bcd_shift;
        end
      end
      WR_DATA: begin
        state_next     = WR_SIGN;
        tube_we_next   = 1'b1;
        tube_addr_next = 1'b1;
        tube_din_next  = {31'b0, neg_reg};
      end
      WR_SIGN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      value_reg     <= '0;
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      lost_reg      <= 1'b0;
      shift_reg     <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      tube_we_reg   <= 1'b0;
      tube_addr_reg <= 1'b0;
      tube_din_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      value_reg     <= value_next;
      neg_reg       <= neg_next;
      ovf_reg       <= ovf_next;
      lost_reg      <= lost_next;
      shift_reg     <= shift_next;
      bcd_reg       <= bcd_next;
      cnt_reg       <= cnt_next;
      tube_we_reg   <= tube_we_next;
      tube_addr_reg <= tube_addr_next;
      tube_din_reg  <= tube_din_next;
    end
  end

  assign tube_WE   = tube_we_reg;
  assign tube_addr = tube_addr_reg;
  assign tube_din  = tube_din_reg;

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_OVF]  = ovf_reg;
    status_word[STAT_LOST] = lost_reg;
  end

  assign RD = addr ? status_word : value_reg;

endmodule
